// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for an N-digit common-cathode
// 7-segment display with hex decode, per-digit decimal point and blanking.
//
// The load strobe copies value/dp_mask/blank_mask into a shadow register as a
// single unit, so a digit never shows a mix of old and new data. A prescaler
// holds each digit for SCAN_DIV cycles before the scan moves to the next one.
//
// Optional feature (macro LEADING_ZERO_BLANK_EN): when the macro is defined,
// leading zero digits are suppressed, with the decision taken from the shadow
// register. Digit 0 is never suppressed. When it is undefined, only
// blank_mask blanks a digit.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         scan enable; 0 blanks the outputs and freezes the scan
//   load       1-cycle strobe that captures value/dp_mask/blank_mask
//   value      hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_mask    per-digit decimal point request
//   blank_mask per-digit forced blank
//   seg        {a,b,c,d,e,f,g,dp}, active-high, registered
//   digit_sel  one-hot digit enable, registered (inverted if DIGIT_ACTIVE_LOW)
//   scan_tick  1-cycle pulse in the cycle whose closing edge advances the digit
module seg_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 1000,
  parameter int DIGIT_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    scan_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           cnt, cnt_next;
  logic [IW-1:0]           idx, idx_next;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_blank;
  logic [NUM_DIGITS-1:0]   lz;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   sel_next;

  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 8'hFC;
      4'h1: decode = 8'h60;
      4'h2: decode = 8'hDA;
      4'h3: decode = 8'hF2;
      4'h4: decode = 8'h66;
      4'h5: decode = 8'hB6;
      4'h6: decode = 8'hBE;
      4'h7: decode = 8'hE0;
      4'h8: decode = 8'hFE;
      4'h9: decode = 8'hF6;
      4'hA: decode = 8'hEE;
      4'hB: decode = 8'h3E;
      4'hC: decode = 8'h9C;
      4'hD: decode = 8'h7A;
      4'hE: decode = 8'h9E;
      default: decode = 8'h8E;
    endcase
  endfunction

  assign wrap = en && (cnt == CNT_MAX);

  // Combinational so that a reset or a dropped enable silences it immediately.
  assign scan_tick = wrap && !rst;

  // State register: scan position, shadow data and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      sh_value  <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      seg       <= '0;
      digit_sel <= SEL_IDLE;
    end else begin
      cnt       <= cnt_next;
      idx       <= idx_next;
      seg       <= seg_next;
      digit_sel <= sel_next;
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp_mask;
        sh_blank <= blank_mask;
      end
    end
  end

  // Next-state logic for the prescaler and digit index.
  always_comb begin
    cnt_next = cnt;
    idx_next = idx;
    if (en) begin
      if (wrap) begin
        cnt_next = '0;
        idx_next = (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; a digit is a leading zero while every
  // nibble above it, and its own, is zero. Digit 0 is excluded.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz       = '0;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      all_zero = all_zero && (sh_value[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      lz[NUM_DIGITS-1-k] = all_zero;
    end
  end
`else
  assign lz = '0;
`endif

  // Output logic: select the current digit and build its segment pattern.
  always_comb begin
    sel_next = '0;
    seg_next = '0;
    if (en) begin
      sel_next[idx] = 1'b1;
      if (sh_blank[idx]) begin
        seg_next = '0;
      end else if (lz[idx]) begin
        seg_next = {7'b0, sh_dp[idx]};
      end else begin
        seg_next = decode(sh_value[4*idx +: 4]) | {7'b0, sh_dp[idx]};
      end
    end
    if (DIGIT_ACTIVE_LOW != 0) begin
      sel_next = ~sel_next;
    end
  end

endmodule
